// File: rtl/dec_scan.sv
// One-hot decoder with direct-select and auto-scan modes.
// All outputs are registered one cycle after the sampled controls.
module dec_scan #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     sel,
  input  logic             load,
  output logic [0:2**N-1]  D,
  output logic [N-1:0]     idx,
  output logic             valid,
  output logic             wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);

  logic [N-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          mode_q, mode_d;
  logic          en_q, en_d;
  logic [0:W-1]  d_q, d_d;
  logic [N-1:0]  idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [N-1:0]  src;

  always_comb begin
    ptr_d  = ptr_q;
    hcnt_d = hcnt_q;
    mode_d = mode_q;
    en_d   = en;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    src    = ptr_q;

    if (en) begin
      mode_d = mode;
      if (!mode || load) begin
        ptr_d  = sel;
        hcnt_d = '0;
        src    = sel;
      end else if (mode != mode_q) begin
        // Entering scan: resume from the last direct select, no step this edge.
        hcnt_d = '0;
      end else if (!en_q) begin
        // First edge after a disable only redisplays ptr; hcnt stays frozen.
        hcnt_d = hcnt_q;
      end else if (hcnt_q == HoldLast) begin
        hcnt_d = '0;
        ptr_d  = ptr_q + N'(1);
        wrap_d = &ptr_q;
        src    = ptr_q + N'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
      idx_d = src;
    end

    for (int unsigned k = 0; k < W; k++) begin
      d_d[k] = en && (src == N'(k));
    end
    valid_d = |d_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      hcnt_q  <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      d_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign D     = d_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: two N=3 instances (HOLD=1 and HOLD=2) against a rule-level model,
// plus literal checks of the directed scenarios.
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load;
  logic [2:0] sel;

  logic [0:7] d_a, d_b;
  logic [2:0] idx_a, idx_b;
  logic       valid_a, valid_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  dec_scan #(.N(3), .HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .D(d_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
  );

  dec_scan #(.N(3), .HOLD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .D(d_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
  );

  typedef struct {
    int ptr;
    int age;
    bit mprev;
    bit eprev;
    int pos;
    int idx;
    bit wrap;
  } model_t;

  model_t ma = '{0, 0, 1'b0, 1'b0, -1, 0, 1'b0};
  model_t mb = '{0, 0, 1'b0, 1'b0, -1, 0, 1'b0};
  int     errors = 0;
  int     checks = 0;
  bit     cmp_on = 1'b0;

  function automatic model_t step(model_t s, bit r, bit e, bit m, bit l, int sl, int hold);
    model_t n = s;
    if (!r) begin
      n = '{0, 0, 1'b0, 1'b0, -1, 0, 1'b0};
      return n;
    end
    n.eprev = e;
    n.wrap  = 1'b0;
    if (!e) begin
      n.pos = -1;
      return n;
    end
    n.mprev = m;
    if (!m || l) begin
      n.ptr = sl;
      n.age = 0;
    end else if (m != s.mprev) begin
      n.age = 0;
    end else if (!s.eprev) begin
      n.age = s.age;
    end else if (s.age == hold - 1) begin
      n.age  = 0;
      n.wrap = (s.ptr == 7);
      n.ptr  = (s.ptr + 1) % 8;
    end else begin
      n.age = s.age + 1;
    end
    n.pos = n.ptr;
    n.idx = n.ptr;
    return n;
  endfunction

  function automatic logic [7:0] vec(int pos);
    logic [7:0] v = 8'd0;
    if (pos >= 0) v[7-pos] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst_n, en, mode, load, int'(sel), 1);
    mb = step(mb, rst_n, en, mode, load, int'(sel), 2);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_D",     d_a,                  vec(ma.pos));
      chk("a_idx",   {5'd0, idx_a},        8'(ma.idx));
      chk("a_valid", {7'd0, valid_a},      {7'd0, ma.pos >= 0});
      chk("a_wrap",  {7'd0, wrap_a},       {7'd0, ma.wrap});
      chk("b_D",     d_b,                  vec(mb.pos));
      chk("b_idx",   {5'd0, idx_b},        8'(mb.idx));
      chk("b_valid", {7'd0, valid_b},      {7'd0, mb.pos >= 0});
      chk("b_wrap",  {7'd0, wrap_b},       {7'd0, mb.wrap});
    end
  end

  task automatic drive(bit r, bit e, bit m, bit l, logic [2:0] s);
    rst_n = r;
    en    = e;
    mode  = m;
    load  = l;
    sel   = s;
    @(posedge clk);
    #1;
  endtask

  bit mode_r;

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 3'd0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
    cmp_on = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rst_D",     d_a,               8'h00);
    chk("rst_idx",   {5'd0, idx_a},     8'd0);
    chk("rst_valid", {7'd0, valid_a},   8'd0);
    chk("rst_wrap",  {7'd0, wrap_a},    8'd0);

    // Direct decode sweep
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'(s));
      chk("dir_D", d_a, 8'h80 >> s);
      chk("dir_valid", {7'd0, valid_a}, 8'd1);
    end

    // Disabled sweep: outputs dark, idx frozen at 7
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'(s));
      chk("dis_D", d_a, 8'h00);
      chk("dis_idx", {5'd0, idx_a}, 8'd7);
    end

    // HOLD=2 scan from reset: idx 0,0,1,1,...,7,7,0 with wrap on the last
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      chk("h2_idx", {5'd0, idx_b}, 8'(((i - 1) / 2) % 8));
      chk("h2_wrap", {7'd0, wrap_b}, {7'd0, i == 17});
    end

    // HOLD=1 scan to ptr=7, then load collides with the wrap
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk("pre_load_idx", {5'd0, idx_a}, 8'd7);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    chk("load_idx", {5'd0, idx_a}, 8'd3);
    chk("load_D", d_a, 8'b0001_0000);
    chk("load_wrap", {7'd0, wrap_a}, 8'd0);

    // Freeze for three cycles, then resume at the same index
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      chk("frz_D", d_a, 8'h00);
      chk("frz_idx", {5'd0, idx_a}, 8'd3);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk("reen_D", d_a, 8'b0001_0000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk("reen_step_D", d_a, 8'b0000_1000);

    // Reset mid-scan
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd6);
    chk("mid_rst_D", d_a, 8'h00);
    chk("mid_rst_idx", {5'd0, idx_a}, 8'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6);
    chk("post_rst_D", d_a, 8'h80);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6);
    chk("post_rst_step_D", d_a, 8'h40);

    // Randomized traffic against the model
    mode_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, mode_r,
            $urandom_range(0, 15) == 0, 3'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
